dual_issue_stage: RTL

//  Decode/issue stage directly upstream of the dual-port register file. Buffers
//  pre-decoded instructions from fetch and drives the file's four read addresses.

---
 rtl/issue_pkg.sv | 18 +
 rtl/dual_issue_stage_if.sv | 41 ++++
 rtl/issue_fifo.sv | 60 ++++++
 rtl/dual_issue_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and helpers for the dual-issue decode stage
package issue_pkg;
    localparam int REG_W = 5;
    localparam int NREG  = 32;

    // Decoded control fields; the opaque payload travels alongside in the buffer.
    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             mem;
    } ibuf_entry_t;

    function automatic logic sb_hit(input logic [NREG-1:0] sb, input logic [REG_W-1:0] r);
        return (r != '0) && sb[r];
    endfunction
endpackage

// File: rtl/dual_issue_stage_if.sv
// rtl/dual_issue_stage_if.sv - fetch, register-file, execute and writeback signals of the issue stage
interface dual_issue_stage_if #(parameter int PAYLOAD_W = 32);
    logic [1:0]           in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload0, in_payload1;
    logic [4:0]           in_rs0, in_rs1, in_rt0, in_rt1, in_rd0, in_rd1;
    logic                 in_we0, in_we1, in_mem0, in_mem1;
    logic [4:0]           readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2;
    logic [31:0]          readdata1_1, readdata2_1, readdata1_2, readdata2_2;
    logic                 ex_ready;
    logic                 iss_valid_1, iss_valid_2;
    logic [PAYLOAD_W-1:0] iss_payload_1, iss_payload_2;
    logic [4:0]           iss_rd_1, iss_rd_2;
    logic                 iss_we_1, iss_we_2, iss_mem_1, iss_mem_2;
    logic [31:0]          iss_opa_1, iss_opb_1, iss_opa_2, iss_opb_2;
    logic                 wb_we_1, wb_we_2;
    logic [4:0]           wb_addr_1, wb_addr_2;
    logic                 flush;

    modport slave (
        input  in_valid, in_payload0, in_payload1, in_rs0, in_rs1, in_rt0, in_rt1,
               in_rd0, in_rd1, in_we0, in_we1, in_mem0, in_mem1,
               readdata1_1, readdata2_1, readdata1_2, readdata2_2,
               ex_ready, wb_we_1, wb_we_2, wb_addr_1, wb_addr_2, flush,
        output in_ready, readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2,
               iss_valid_1, iss_valid_2, iss_payload_1, iss_payload_2, iss_rd_1, iss_rd_2,
               iss_we_1, iss_we_2, iss_mem_1, iss_mem_2,
               iss_opa_1, iss_opb_1, iss_opa_2, iss_opb_2
    );

    modport master (
        output in_valid, in_payload0, in_payload1, in_rs0, in_rs1, in_rt0, in_rt1,
               in_rd0, in_rd1, in_we0, in_we1, in_mem0, in_mem1,
               readdata1_1, readdata2_1, readdata1_2, readdata2_2,
               ex_ready, wb_we_1, wb_we_2, wb_addr_1, wb_addr_2, flush,
        input  in_ready, readaddr1_1, readaddr2_1, readaddr1_2, readaddr2_2,
               iss_valid_1, iss_valid_2, iss_payload_1, iss_payload_2, iss_rd_1, iss_rd_2,
               iss_we_1, iss_we_2, iss_mem_1, iss_mem_2,
               iss_opa_1, iss_opb_1, iss_opa_2, iss_opb_2
    );
endinterface

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - circular instruction buffer with up to two pushes and two pops per cycle
module issue_fifo
    import issue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0]             push_n,
    input  logic [1:0]             pop_n,
    input  ibuf_entry_t            push_e0,
    input  ibuf_entry_t            push_e1,
    input  logic [PAYLOAD_W-1:0]   push_p0,
    input  logic [PAYLOAD_W-1:0]   push_p1,
    output ibuf_entry_t            head_e0,
    output ibuf_entry_t            head_e1,
    output logic [PAYLOAD_W-1:0]   head_p0,
    output logic [PAYLOAD_W-1:0]   head_p1,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ibuf_entry_t          ent [DEPTH];
    logic [PAYLOAD_W-1:0] pay [DEPTH];
    logic [AW-1:0]        rptr, wptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + AW'(pop_n);
            wptr  <= wptr + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Storage needs no reset: entries are only observed through the count.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_n != 2'd0) begin
                ent[wptr] <= push_e0;
                pay[wptr] <= push_p0;
            end
            if (push_n == 2'd2) begin
                ent[wptr + AW'(1)] <= push_e1;
                pay[wptr + AW'(1)] <= push_p1;
            end
        end
    end

    assign head_e0 = ent[rptr];
    assign head_e1 = ent[rptr + AW'(1)];
    assign head_p0 = pay[rptr];
    assign head_p1 = pay[rptr + AW'(1)];
endmodule

// File: rtl/dual_issue_stage.sv
// rtl/dual_issue_stage.sv - in-order dual-issue stage with scoreboard and pair hazard checks
module dual_issue_stage
    import issue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    dual_issue_stage_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    ibuf_entry_t          in_e0, in_e1, a, b;
    logic [PAYLOAD_W-1:0] a_pay, b_pay;
    logic [CW-1:0]        count;
    logic [NREG-1:0]      scoreboard, sb_set, sb_clr;
    logic                 push, has_a, has_b, upd;
    logic                 a_ok, b_ok, a_wr, raw, waw, b_blk;
    logic [1:0]           push_n, pop_n;

    assign in_e0 = '{rs: bus.in_rs0, rt: bus.in_rt0, rd: bus.in_rd0, we: bus.in_we0, mem: bus.in_mem0};
    assign in_e1 = '{rs: bus.in_rs1, rt: bus.in_rt1, rd: bus.in_rd1, we: bus.in_we1, mem: bus.in_mem1};

    assign bus.in_ready = !rst && (count <= CW'(DEPTH - 2));
    assign push         = bus.in_valid[0] && bus.in_ready && !bus.flush;
    assign push_n       = push ? (bus.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;

    issue_fifo #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push_n  (push_n),
        .pop_n   (pop_n),
        .push_e0 (in_e0),
        .push_e1 (in_e1),
        .push_p0 (bus.in_payload0),
        .push_p1 (bus.in_payload1),
        .head_e0 (a),
        .head_e1 (b),
        .head_p0 (a_pay),
        .head_p1 (b_pay),
        .count   (count)
    );

    assign has_a = (count != '0);
    assign has_b = (count >= CW'(2));

    assign bus.readaddr1_1 = has_a ? a.rs : '0;
    assign bus.readaddr2_1 = has_a ? a.rt : '0;
    assign bus.readaddr1_2 = has_b ? b.rs : '0;
    assign bus.readaddr2_2 = has_b ? b.rt : '0;

    // B is checked against A as if A had already written, since both leave together.
    assign a_ok  = has_a && !(sb_hit(scoreboard, a.rs) || sb_hit(scoreboard, a.rt) ||
                              (a.we && sb_hit(scoreboard, a.rd)));
    assign b_blk = sb_hit(scoreboard, b.rs) || sb_hit(scoreboard, b.rt) ||
                   (b.we && sb_hit(scoreboard, b.rd));
    assign a_wr  = a.we && (a.rd != '0);
    assign raw   = a_wr && ((b.rs == a.rd) || (b.rt == a.rd));
    assign waw   = a_wr && b.we && (b.rd == a.rd);
    assign b_ok  = a_ok && has_b && !b_blk && !raw && !waw && !(a.mem && b.mem);

    assign upd   = bus.ex_ready || !bus.iss_valid_1;
    assign pop_n = (upd && !bus.flush) ? ({1'b0, a_ok} + {1'b0, b_ok}) : 2'd0;

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (upd && !bus.flush) begin
            if (a_ok && a.we) sb_set[a.rd] = 1'b1;
            if (b_ok && b.we) sb_set[b.rd] = 1'b1;
        end
        if (bus.wb_we_1) sb_clr[bus.wb_addr_1] = 1'b1;
        if (bus.wb_we_2) sb_clr[bus.wb_addr_2] = 1'b1;
    end

    // Flush leaves the scoreboard alone so in-flight writers still clear their bits.
    always_ff @(posedge clk) begin
        if (rst) scoreboard <= '0;
        else     scoreboard <= ((scoreboard & ~sb_clr) | sb_set) & ~NREG'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.iss_valid_1   <= 1'b0;
            bus.iss_valid_2   <= 1'b0;
            bus.iss_payload_1 <= '0;
            bus.iss_payload_2 <= '0;
            bus.iss_rd_1      <= '0;
            bus.iss_rd_2      <= '0;
            bus.iss_we_1      <= 1'b0;
            bus.iss_we_2      <= 1'b0;
            bus.iss_mem_1     <= 1'b0;
            bus.iss_mem_2     <= 1'b0;
            bus.iss_opa_1     <= '0;
            bus.iss_opb_1     <= '0;
            bus.iss_opa_2     <= '0;
            bus.iss_opb_2     <= '0;
        end else if (bus.flush) begin
            bus.iss_valid_1 <= 1'b0;
            bus.iss_valid_2 <= 1'b0;
        end else if (upd) begin
            bus.iss_valid_1   <= a_ok;
            bus.iss_valid_2   <= b_ok;
            bus.iss_payload_1 <= a_pay;
            bus.iss_payload_2 <= b_pay;
            bus.iss_rd_1      <= a.rd;
            bus.iss_rd_2      <= b.rd;
            bus.iss_we_1      <= a.we;
            bus.iss_we_2      <= b.we;
            bus.iss_mem_1     <= a.mem;
            bus.iss_mem_2     <= b.mem;
            bus.iss_opa_1     <= bus.readdata1_1;
            bus.iss_opb_1     <= bus.readdata2_1;
            bus.iss_opa_2     <= bus.readdata1_2;
            bus.iss_opb_2     <= bus.readdata2_2;
        end
    end
endmodule
